db_to_linear_gain: RTL and testbench

//  Inverse of the 12-bit-binary-to-dB converter: maps a signed dB gain (from the compression

---
 rtl/db2lin_pkg.sv | 35 +++
 rtl/db2lin_mantissa_rom.sv | 16 +
 rtl/db_to_linear_gain.sv | 99 +++++++++
 tb/tb_db_to_linear_gain.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/db2lin_pkg.sv
// db2lin_pkg: shared constants, state encoding and mantissa tables for db_to_linear_gain.
// DB2LIN_HALF_DB_EN selects 0.5 dB input resolution (STEP=12, 12-entry table).
package db2lin_pkg;

    localparam int GAIN_W = 16;
    localparam int MANT_W = 13;
    localparam int DB_W = 9;
    localparam int Q_W = 6;

`ifdef DB2LIN_HALF_DB_EN
    localparam int DB_SCALE = 2;
    localparam logic signed [DB_W-1:0] STEP = 9'sd12;
`else
    localparam int DB_SCALE = 1;
    localparam logic signed [DB_W-1:0] STEP = 9'sd6;
`endif

    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        SCALE
    } state_t;

    // round(4096 * 10^(r/20)) for r = 0..5 dB
    localparam logic [MANT_W-1:0] LUT_DB [0:5] = '{
        13'd4096, 13'd4596, 13'd5157, 13'd5786, 13'd6492, 13'd7284
    };

    // round(4096 * 10^(h/40)) for h = 0..11 half-dB steps
    localparam logic [MANT_W-1:0] LUT_HALF_DB [0:11] = '{
        13'd4096, 13'd4339, 13'd4596, 13'd4868, 13'd5157, 13'd5462,
        13'd5786, 13'd6129, 13'd6492, 13'd6876, 13'd7284, 13'd7715
    };

endpackage

// File: rtl/db2lin_mantissa_rom.sv
// db2lin_mantissa_rom: residual-dB index to 13-bit Q.12 mantissa.
// Table chosen by DB2LIN_HALF_DB_EN; out-of-range indices return 0.
module db2lin_mantissa_rom
    import db2lin_pkg::*;
(
    input  logic [3:0]        idx,
    output logic [MANT_W-1:0] mantissa
);

`ifdef DB2LIN_HALF_DB_EN
    assign mantissa = (idx < 4'd12) ? LUT_HALF_DB[idx] : '0;
`else
    assign mantissa = (idx < 4'd6) ? LUT_DB[idx[2:0]] : '0;
`endif

endmodule

// File: rtl/db_to_linear_gain.sv
// db_to_linear_gain: signed dB gain to unsigned Q4.12 linear gain via octave reduction + mantissa LUT.
// DB2LIN_HALF_DB_EN switches the input LSB to 0.5 dB.
module db_to_linear_gain
    import db2lin_pkg::*;
#(
    parameter int MIN_DB = -72,
    parameter int MAX_DB = 12
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic signed [DB_W-1:0] input_db,
    output logic [GAIN_W-1:0]      output_gain,
    output logic                   busy,
    output logic                   done
);

    localparam logic signed [DB_W-1:0] MIN_LIM = DB_W'(MIN_DB * DB_SCALE);
    localparam logic signed [DB_W-1:0] MAX_LIM = DB_W'(MAX_DB * DB_SCALE);

    state_t                  state, state_n;
    logic signed [DB_W-1:0]  d, d_n;
    logic signed [Q_W-1:0]   q, q_n;
    logic                    mute, mute_n;
    logic [GAIN_W-1:0]       gain_n;
    logic                    busy_n, done_n;
    logic [MANT_W-1:0]       mantissa;
    logic [Q_W-1:0]          amt;
    logic [GAIN_W-1:0]       wide, shifted;

    db2lin_mantissa_rom u_rom (
        .idx      (d[3:0]),
        .mantissa (mantissa)
    );

    // Each octave is treated as exactly x2, so the exponent q is a plain shift.
    assign wide    = {{(GAIN_W-MANT_W){1'b0}}, mantissa};
    assign amt     = q[Q_W-1] ? Q_W'(-q) : Q_W'(q);
    assign shifted = q[Q_W-1] ? (wide >> amt) : (wide << amt);

    always_comb begin
        state_n = state;
        d_n     = d;
        q_n     = q;
        mute_n  = mute;
        gain_n  = output_gain;
        busy_n  = busy;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                busy_n = start;
                if (start) begin
                    state_n = REDUCE;
                    d_n     = (input_db > MAX_LIM) ? MAX_LIM : input_db;
                    mute_n  = input_db < MIN_LIM;
                    q_n     = '0;
                end
            end
            REDUCE: begin
                if (mute || (!d[DB_W-1] && d < STEP)) begin
                    state_n = SCALE;
                end else if (d >= STEP) begin
                    d_n = d - STEP;
                    q_n = q + 6'sd1;
                end else begin
                    d_n = d + STEP;
                    q_n = q - 6'sd1;
                end
            end
            SCALE: begin
                gain_n  = mute ? '0 : shifted;
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            d           <= '0;
            q           <= '0;
            mute        <= 1'b0;
            output_gain <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            d           <= d_n;
            q           <= q_n;
            mute        <= mute_n;
            output_gain <= gain_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

endmodule

// File: tb/tb_db_to_linear_gain.sv
// tb_db_to_linear_gain: directed vectors with hand-computed gains and latencies.
// Covers both input resolutions selected by DB2LIN_HALF_DB_EN.
module tb_db_to_linear_gain;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic signed [8:0] input_db = '0;
    logic [15:0]       output_gain;
    logic              busy;
    logic              done;

    int n_cmp = 0;
    int n_err = 0;

    db_to_linear_gain dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .input_db    (input_db),
        .output_gain (output_gain),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int observed, input int expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic convert(input string tag, input int v, input int eg, input int el);
        int lat = 0;
        @(negedge clock);
        input_db = 9'(v);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        chk({tag, "_busy_start"}, int'(busy), 1);
        do begin
            @(posedge clock);
            #1 lat++;
        end while (!done && lat < 40);
        chk({tag, "_latency"}, lat, el);
        chk({tag, "_gain"}, int'(output_gain), eg);
        chk({tag, "_busy_done"}, int'(busy), 1);
        @(posedge clock);
        #1;
        chk({tag, "_done_clear"}, int'(done), 0);
        chk({tag, "_busy_clear"}, int'(busy), 0);
        chk({tag, "_gain_hold"}, int'(output_gain), eg);
    endtask

    initial begin
        int n_done;
        int lat;
        int far_v;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_gain", int'(output_gain), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_busy", int'(busy), 0);
        @(negedge clock);
        reset = 1'b1;

`ifdef DB2LIN_HALF_DB_EN
        far_v = -144;
        convert("zero", 0, 4096, 2);
        convert("m0p5", -1, 3857, 3);
        convert("p1p5", 3, 4868, 2);
        convert("p12", 24, 16384, 4);
        convert("clamp", 100, 16384, 4);
        convert("m6", -12, 2048, 3);
        convert("min", -144, 1, 14);
        convert("mute", -145, 0, 2);
        convert("mute_far", -200, 0, 2);
`else
        far_v = -72;
        convert("zero", 0, 4096, 2);
        convert("p5", 5, 7284, 2);
        convert("p11", 11, 14568, 3);
        convert("p12", 12, 16384, 4);
        convert("clamp", 100, 16384, 4);
        convert("m6", -6, 2048, 3);
        convert("m7", -7, 1821, 4);
        convert("min", -72, 1, 14);
        convert("mute", -73, 0, 2);
        convert("mute_far", -100, 0, 2);
`endif

        // A second start while busy must be ignored entirely.
        @(negedge clock);
        input_db = 9'(far_v);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        n_done = 0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            start = (i == 3);
            input_db = '0;
            @(posedge clock);
            #1;
            if (done) begin
                n_done++;
                lat = i;
            end
        end
        start = 1'b0;
        chk("ignore_done_count", n_done, 1);
        chk("ignore_latency", lat, 14);
        chk("ignore_gain", int'(output_gain), 1);

        // Reset in the middle of the reduction loop aborts without a done.
        @(negedge clock);
        input_db = 9'(far_v);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("abort_gain", int'(output_gain), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        @(negedge clock);
        reset = 1'b1;
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1 if (done) n_done++;
        end
        chk("abort_no_done", n_done, 0);
        convert("after_abort", 0, 4096, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
